// File: rtl/mini_arith_pipe.sv
// Two-stage add/sub pipeline with a chaining accumulator and N/Z/C/V flags.
// Latency: 2 cycles from acceptance to out_valid; throughput 1 per cycle.
// Backpressure: out_ready=0 stalls stage 2, then stage 1; in_ready drops only when both are full.
module mini_arith_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_sel,
    input  logic             acc_clr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             zero;
        logic             neg;
        logic             ovf;
    } res_t;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] g_op;
    logic             cin;
    logic [WIDTH:0]   sum;
    res_t             calc_dat;
    res_t             s1_dat;
    res_t             s2_dat;
    logic             s1_vld;
    logic             s2_vld;
    logic             accept;
    logic             s2_ld;

    // All four operations collapse onto one adder: a-1 = a+~0, a-b = a+~b+1, -b = 0+~b+1.
    always_comb begin
        a_sel = acc_sel ? acc : a;
        a_op  = (s == 2'b11) ? '0 : a_sel;
        case (s)
            2'b00:   g_op = '1;
            2'b01:   g_op = b;
            default: g_op = ~b;
        endcase
        cin = s[1];
        sum = {1'b0, a_op} + {1'b0, g_op} + {{WIDTH{1'b0}}, cin};

        calc_dat.res   = sum[WIDTH-1:0];
        calc_dat.carry = sum[WIDTH];
        calc_dat.zero  = (sum[WIDTH-1:0] == '0);
        calc_dat.neg   = sum[WIDTH-1];
        calc_dat.ovf   = (a_op[WIDTH-1] == g_op[WIDTH-1]) && (sum[WIDTH-1] != a_op[WIDTH-1]);
    end

    assign s2_ld    = (!s2_vld || out_ready) && s1_vld;
    assign in_ready = !s1_vld || !s2_vld || out_ready;
    assign accept   = in_valid && in_ready;

    // Accumulator update on acceptance wins over clear, so the op sees the pre-clear value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (accept) begin
            acc <= calc_dat.res;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else if (accept) begin
            s1_vld <= 1'b1;
            s1_dat <= calc_dat;
        end else if (s2_ld) begin
            s1_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_dat <= '0;
        end else if (s2_ld) begin
            s2_vld <= 1'b1;
            s2_dat <= s1_dat;
        end else if (out_ready) begin
            s2_vld <= 1'b0;
        end
    end

    assign out_valid = s2_vld;
    assign result    = s2_dat.res;
    assign carry     = s2_dat.carry;
    assign zero      = s2_dat.zero;
    assign neg       = s2_dat.neg;
    assign ovf       = s2_dat.ovf;

endmodule

// File: doc/mini_arith_pipe.md
MINI_ARITH_PIPE -- requirements
Module: mini_arith_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port s  input  2  operation select: 00 a-1, 01 a+b, 10 a-b, 11 -b.
REQ-005 The block SHALL have port a  input  WIDTH  operand A.
REQ-006 The block SHALL have port b  input  WIDTH  operand B.
REQ-007 The block SHALL have port acc_sel  input  1  when 1, use the accumulator in place of a.
REQ-008 The block SHALL have port acc_clr  input  1  synchronous clear of the accumulator.
REQ-009 The block SHALL have port in_valid  input  1  request valid.
REQ-010 The block SHALL have port in_ready  output  1  block can accept the request.
REQ-011 The block SHALL have port out_valid  output  1  result valid.
REQ-012 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 The block SHALL have port result  output  WIDTH  arithmetic result.
REQ-014 The block SHALL have port carry  output  1  carry-out of the WIDTH-bit addition.
REQ-015 The block SHALL have port zero  output  1  result == 0.
REQ-016 The block SHALL have port neg  output  1  result MSB.
REQ-017 The block SHALL have port ovf  output  1  two's-complement overflow.

Function
REQ-018 The block SHALL form the datapath as follows: A_op = (acc_sel ? acc : a) AND NOT(s==11); G = all-ones for s=00, b for s=01, ~b for s=10 or s=11; cin = s[1]; {carry,result} = A_op + G + cin, computed modulo 2^WIDTH.
REQ-019 The block SHALL set ovf when MSB(A_op) == MSB(G) and MSB(result) != MSB(A_op).
REQ-020 The block SHALL treat the request as accepted on a rising edge where in_valid && in_ready.
REQ-021 The block SHALL be a two-register pipeline. Stage 1 captures result and flags at acceptance. Stage 2 is the output register. Latency from acceptance to out_valid is 2 cycles, and throughput is 1 per cycle with no stall.
REQ-022 The block SHALL use the following advance rules: stage 2 loads when (!v2 || out_ready) && v1; in_ready = !v1 || (!v2 || out_ready). Both are combinational, with no dependence of in_ready on in_valid.
REQ-023 The block SHALL hold result, carry, zero, neg, ovf and out_valid stable while out_valid && !out_ready.
REQ-024 The block SHALL clear out_valid on the edge where out_valid && out_ready, unless stage 1 holds a valid entry; in that case stage 2 reloads from stage 1 on the same edge.
REQ-025 The block SHALL load acc with the computed result on every acceptance, giving back-to-back chaining with no hazard (acc_sel on the next request sees this value).
REQ-026 The block SHALL zero acc on an edge where acc_clr is 1 and no acceptance occurs. When acc_clr and an acceptance coincide, acc SHALL take the new result, and the accepted operation SHALL use the pre-clear acc value.
REQ-027 The block SHALL ignore s, a, b and acc_sel when no acceptance occurs.
REQ-028 The block SHALL ignore in_valid while in_ready is 0; the request SHALL not be accepted.

Reset
REQ-029 While rst is 1, the block SHALL asynchronously force the stage-1 and stage-2 valid bits to 0, acc to 0, result to 0, and carry, zero, neg and ovf to 0. in_ready SHALL therefore be 1.
REQ-030 A request presented in the cycle in which rst is asserted SHALL be discarded.
REQ-031 After rst deasserts, the first rising edge SHALL be able to accept a request.
REQ-032 Results in flight when rst asserts mid-operation SHALL be lost and SHALL never appear on out_valid.

Verification
REQ-033 The bench SHALL cover the following scenarios, with WIDTH=8 and out_ready held at 1 unless stated:
- Assert rst, then sample: out_valid=0, result=0, all flags 0, in_ready=1.
- s=00, a=5: after 2 cycles, result=4, carry=1, zero=0, neg=0, ovf=0.
- s=10, a=3, b=5: result=254, carry=0, neg=1, ovf=0.
- s=11, b=0: result=0, carry=1, zero=1. s=01, a=127, b=1: result=128, ovf=1, neg=1.
- Accumulate chain: first send s=01, a=10, b=7, acc_sel=0; then send s=01, b=3, acc_sel=1. Results are 17 then 20. Then acc_clr=1 with no request, then s=01, b=1, acc_sel=1: result=1.
- Backpressure: hold out_ready=0 and drive in_valid=1 for 4 cycles. Exactly 2 requests are accepted, in_ready=0 thereafter, and the first result is held stable. Release out_ready and check that results arrive in order, with no loss or duplication.
